// File: rtl/vc_scheduler.sv
// Weighted VC0/VC1 -> D0/D1 word scheduler.
// Registered pop stage feeding a combinational push stage.
module vc_scheduler #(
  parameter int DATA_W     = 6,
  parameter int DEST_BIT   = 4,
  parameter int VC0_WEIGHT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              empty_vc0,
  input  logic              empty_vc1,
  input  logic              almost_full_d0,
  input  logic              almost_full_d1,
  input  logic [DATA_W-1:0] data_vc0,
  input  logic [DATA_W-1:0] data_vc1,
  output logic              pop_vc0,
  output logic              pop_vc1,
  output logic              push_d0,
  output logic              push_d1,
  output logic [DATA_W-1:0] data_out,
  output logic              stall
);

  localparam int CW = $clog2(VC0_WEIGHT + 1);
  localparam logic [CW-1:0] WMAX = CW'(VC0_WEIGHT);

  typedef enum logic [1:0] {
    DISABLED,
    RUN,
    BLOCKED
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic              valid_q;
  logic              sel_q;
  logic              full_any;
  logic              can_pop;
  logic              g0;
  logic              g1;
  logic              pv;
  logic [DATA_W-1:0] word;

  // Pop gating uses live inputs so backpressure bites immediately.
  always_comb begin
    full_any = almost_full_d0 | almost_full_d1;
    can_pop  = reset & (state == RUN) & active & ~full_any;
    g1 = can_pop & ~empty_vc1 & (empty_vc0 | (cnt == WMAX));
    g0 = can_pop & ~g1 & ~empty_vc0;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      DISABLED: begin
        if (active) state_nx = RUN;
      end
      RUN: begin
        if (!active)       state_nx = DISABLED;
        else if (full_any) state_nx = BLOCKED;
      end
      BLOCKED: begin
        if (!active)        state_nx = DISABLED;
        else if (!full_any) state_nx = RUN;
      end
      default: state_nx = DISABLED;
    endcase
  end

  always_comb begin
    cnt_nx = cnt;
    if (g1)
      cnt_nx = '0;
    else if (g0 && cnt != WMAX)
      cnt_nx = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= DISABLED;
      cnt     <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      valid_q <= g0 | g1;
      if (g0 | g1) sel_q <= g1;
    end
  end

  // In-flight word always lands; the threshold reserved its slot.
  always_comb begin
    pv       = valid_q & reset;
    word     = sel_q ? data_vc1 : data_vc0;
    pop_vc0  = g0;
    pop_vc1  = g1;
    data_out = pv ? word : '0;
    push_d1  = pv & word[DEST_BIT];
    push_d0  = pv & ~word[DEST_BIT];
    stall    = reset & (state == BLOCKED);
  end

endmodule

// File: tb/tb_vc_scheduler.sv
// Scoreboard bench for vc_scheduler with modelled source FIFOs.
// Stimulus queues expectations; the monitor checks at negedge.
module tb_vc_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       active;
  logic       empty_vc0;
  logic       empty_vc1;
  logic       almost_full_d0;
  logic       almost_full_d1;
  logic [5:0] data_vc0 = '0;
  logic [5:0] data_vc1 = '0;
  logic       pop_vc0;
  logic       pop_vc1;
  logic       push_d0;
  logic       push_d1;
  logic [5:0] data_out;
  logic       stall;

  vc_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .empty_vc0      (empty_vc0),
    .empty_vc1      (empty_vc1),
    .almost_full_d0 (almost_full_d0),
    .almost_full_d1 (almost_full_d1),
    .data_vc0       (data_vc0),
    .data_vc1       (data_vc1),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .push_d0        (push_d0),
    .push_d1        (push_d1),
    .data_out       (data_out),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  logic [5:0] mem0 [0:63];
  logic [5:0] mem1 [0:63];
  int wr0 = 0;
  int wr1 = 0;
  int rd0 = 0;
  int rd1 = 0;

  assign empty_vc0 = (rd0 == wr0);
  assign empty_vc1 = (rd1 == wr1);

  // Source FIFOs with one-cycle registered read.
  always @(posedge clk) begin
    if (pop_vc0) begin
      data_vc0 <= mem0[rd0[5:0]];
      rd0 <= rd0 + 1;
    end
    if (pop_vc1) begin
      data_vc1 <= mem1[rd1[5:0]];
      rd1 <= rd1 + 1;
    end
  end

  bit         exp_vc [$];
  logic [5:0] exp_word [$];

  logic       chk_pop = 1'b0;
  logic [1:0] exp_pop_now = 2'b00;
  logic       chk_stall = 1'b0;
  logic       exp_stall = 1'b0;
  logic       fin = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  logic       pend = 1'b0;
  logic       fin_done = 1'b0;
  logic       pop_any;
  logic       push_any;
  logic       exp_push;
  logic [5:0] w;
  bit         v;

  always @(negedge clk) begin
    pop_any  = pop_vc0 | pop_vc1;
    push_any = push_d0 | push_d1;
    if (!reset)
      check("reset_outputs",
            {pop_vc0, pop_vc1, push_d0, push_d1, stall, data_out}, 0);
    if (chk_pop)
      check("pop_timing", {pop_vc1, pop_vc0}, exp_pop_now);
    if (chk_stall)
      check("stall", stall, exp_stall);
    check("dual_pop", pop_vc0 & pop_vc1, 0);
    if (pop_any && !(pop_vc0 && pop_vc1)) begin
      if (exp_vc.size() == 0) begin
        check("unexpected_pop", 1, 0);
      end else begin
        v = exp_vc.pop_front();
        check("pop_order_vc", pop_vc1, v);
      end
    end
    exp_push = pend & reset;
    if (push_any || exp_push)
      check("push_latency", push_any, exp_push);
    if (push_any) begin
      check("dual_push", push_d0 & push_d1, 0);
      if (exp_word.size() == 0) begin
        check("unexpected_push", 1, 0);
      end else begin
        w = exp_word.pop_front();
        check("push_word", {push_d1, push_d0, data_out},
              {w[4], ~w[4], w});
      end
    end
    pend = pop_any;
    if (fin && !fin_done) begin
      fin_done = 1'b1;
      check("pops_left", exp_vc.size(), 0);
      check("pushes_left", exp_word.size(), 0);
    end
  end

  task automatic ld0(input logic [5:0] d);
    mem0[wr0[5:0]] = d;
    wr0++;
  endtask

  task automatic ld1(input logic [5:0] d);
    mem1[wr1[5:0]] = d;
    wr1++;
  endtask

  task automatic ex(input bit c, input logic [5:0] d);
    exp_vc.push_back(c);
    exp_word.push_back(d);
  endtask

  task automatic cy(input logic a, input logic f0, input logic f1,
                    input logic [1:0] ep, input logic es);
    active = a;
    almost_full_d0 = f0;
    almost_full_d1 = f1;
    chk_pop = 1'b1;
    exp_pop_now = ep;
    chk_stall = 1'b1;
    exp_stall = es;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    chk_pop = 1'b0;
    chk_stall = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0;
    active = 1'b1;
    almost_full_d0 = 1'b0;
    almost_full_d1 = 1'b0;
    // Arbitration set: VC0 x3, VC1, VC0 x3, VC1.
    ld0(6'h11); ld0(6'h02); ld0(6'h33);
    ld0(6'h04); ld0(6'h15); ld0(6'h06);
    ld1(6'h2A); ld1(6'h38);
    ex(0, 6'h11); ex(0, 6'h02); ex(0, 6'h33); ex(1, 6'h2A);
    ex(0, 6'h04); ex(0, 6'h15); ex(0, 6'h06); ex(1, 6'h38);
    cy(1, 0, 0, 2'b00, 0);
    cy(1, 0, 0, 2'b00, 0);
    reset = 1'b1;
    cy(1, 0, 0, 2'b00, 0);
    cy(1, 0, 0, 2'b01, 0);
    idle(12);

    // VC0 runs dry after two grants; VC1 takes over.
    ld0(6'h01); ld0(6'h12);
    ld1(6'h20); ld1(6'h31); ld1(6'h0A);
    ex(0, 6'h01); ex(0, 6'h12);
    ex(1, 6'h20); ex(1, 6'h31); ex(1, 6'h0A);
    idle(8);
    // Refill: counter restarted by the VC1 grants.
    ld0(6'h03); ld0(6'h14); ld0(6'h25); ld0(6'h36);
    ld1(6'h17);
    ex(0, 6'h03); ex(0, 6'h14); ex(0, 6'h25);
    ex(1, 6'h17); ex(0, 6'h36);
    idle(8);

    // VC0 only, constant word routed to D1.
    cy(0, 0, 0, 2'b00, 0);
    cy(0, 0, 0, 2'b00, 0);
    repeat (4) begin
      ld0(6'b010011);
      ex(0, 6'b010011);
    end
    cy(1, 0, 0, 2'b00, 0);
    repeat (4) cy(1, 0, 0, 2'b01, 0);
    cy(1, 0, 0, 2'b00, 0);
    idle(2);

    // Backpressure after two pops.
    cy(0, 0, 0, 2'b00, 0);
    ld0(6'h05); ld0(6'h16); ld0(6'h27); ld0(6'h38);
    ex(0, 6'h05); ex(0, 6'h16); ex(0, 6'h27); ex(0, 6'h38);
    cy(1, 0, 0, 2'b00, 0);
    cy(1, 0, 0, 2'b01, 0);
    cy(1, 0, 0, 2'b01, 0);
    cy(1, 1, 0, 2'b00, 0);
    cy(1, 1, 0, 2'b00, 1);
    cy(1, 1, 1, 2'b00, 1);
    cy(1, 0, 0, 2'b00, 1);
    cy(1, 0, 0, 2'b01, 0);
    cy(1, 0, 0, 2'b01, 0);
    cy(1, 0, 0, 2'b00, 0);
    idle(2);

    // Active drops mid-stream.
    cy(0, 0, 0, 2'b00, 0);
    ld0(6'h09); ld0(6'h1A); ld0(6'h2B); ld0(6'h3C);
    ex(0, 6'h09); ex(0, 6'h1A); ex(0, 6'h2B); ex(0, 6'h3C);
    cy(1, 0, 0, 2'b00, 0);
    cy(1, 0, 0, 2'b01, 0);
    cy(1, 0, 0, 2'b01, 0);
    cy(0, 0, 0, 2'b00, 0);
    cy(1, 0, 0, 2'b00, 0);
    cy(1, 0, 0, 2'b01, 0);
    cy(1, 0, 0, 2'b01, 0);
    cy(1, 0, 0, 2'b00, 0);
    idle(2);

    // Reset right after a pop drops the in-flight word.
    cy(0, 0, 0, 2'b00, 0);
    ld0(6'h11); ld0(6'h22);
    exp_vc.push_back(0);
    ex(0, 6'h22);
    cy(1, 0, 0, 2'b00, 0);
    cy(1, 0, 0, 2'b01, 0);
    reset = 1'b0;
    cy(1, 0, 0, 2'b00, 0);
    cy(1, 0, 0, 2'b00, 0);
    reset = 1'b1;
    cy(1, 0, 0, 2'b00, 0);
    cy(1, 0, 0, 2'b01, 0);
    cy(1, 0, 0, 2'b00, 0);
    idle(2);

    fin = 1'b1;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
